punct_conv_encoder: RTL
=======================

PUNCT_CONV_ENCODER -- requirements
Module: punct_conv_encoder

Interface
REQ-001 SHALL have parameter K, default 7: constraint length, 3..9.
REQ-002 SHALL have parameter G0, default 7'o133: generator A; MSB taps current input, LSB taps oldest delay.
REQ-003 SHALL have parameter G1, default 7'o171: generator B; same tap ordering.
REQ-004 SHALL have parameter INITIAL_STATE, default all-zero (K-1 bits): shift-register reset value.
REQ-005 SHALL have port Clock  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port Rate  in  2  code rate: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = reserved (treated as 1/2).
REQ-008 SHALL have port InValid  in  1  InBit is valid.
REQ-009 SHALL have port InBit  in  1  uncoded data bit.
REQ-010 SHALL have port InReady  out  1  block accepts InBit this cycle.
REQ-011 SHALL have port OutValid  out  1  OutBit is valid.
REQ-012 SHALL have port OutBit  out  1  coded, punctured serial bit.
REQ-013 SHALL have port OutReady  in  1  downstream accepts OutBit this cycle.

Function
REQ-014 SHALL accept an input bit only on a cycle with InValid and InReady both high; SHALL deliver an output bit only on a cycle with OutValid and OutReady both high.
REQ-015 SHALL compute, per accepted bit, A = XOR over taps of G0 and B = XOR over taps of G1, using {InBit, s1..s(K-1)}, s1 = most recent previous bit.
REQ-016 SHALL shift InBit into s1 on acceptance only; SHALL leave the register unchanged otherwise.
REQ-017 SHALL keep a puncture position p, 0..period-1; period is 1 for rate 1/2, 2 for 2/3, 3 for 3/4.
REQ-018 SHALL keep bits per position as follows: rate 1/2: A,B. Rate 2/3: p0 A,B; p1 A. Rate 3/4: p0 A,B; p1 A; p2 B.
REQ-019 SHALL emit kept bits A first, then B.
REQ-020 SHALL advance p on each acceptance and wrap to 0 after period-1.
REQ-021 SHALL sample Rate into an internal register only on acceptance at p = 0; a Rate change mid-period SHALL take effect at the next p = 0.
REQ-022 SHALL hold kept bits in a 2-entry pending buffer; OutValid = buffer non-empty; OutBit = oldest pending bit.
REQ-023 SHALL assert InReady when the buffer is empty, or when it holds exactly one bit and OutReady is high (back-to-back).
REQ-024 SHALL present the first kept bit on OutValid the cycle after acceptance (latency 1).
REQ-025 SHALL sustain 1 output bit per cycle with OutReady held high.
REQ-026 SHALL, while OutReady is low, hold OutBit and OutValid stable and drop nothing.
REQ-027 SHALL ignore InBit whenever InValid is low.

Reset
REQ-028 SHALL on Reset set the shift register to INITIAL_STATE, p to 0, the rate register to 1/2, and the buffer to empty.
REQ-029 SHALL reset outputs to OutValid = 0, OutBit = 0, InReady = 1 (first cycle after release).
REQ-030 SHALL, on Reset mid-stream, discard pending coded bits with no partial period output after release.

Structure
REQ-031 SHALL take rate encodings, default G0/G1 and the puncture-keep table (rate, p -> keepA, keepB) from shared package wifi_tx_pkg.
REQ-032 SHALL instantiate one sub-module, conv_encoder_core: parametrised shift register plus parity; computes A,B; shifts on an enable.

Verification
REQ-033 SHALL cover: Reset, Rate = 0, input 1,1,1, OutReady = 1 -> OutBit 1,1,1,0,0,1.
REQ-034 SHALL cover: Reset, Rate = 2, input 1,1,1 -> OutBit 1,1,1,1 (4 bits), then p = 0.
REQ-035 SHALL cover: Reset, Rate = 1, input 1,1,1 -> OutBit 1,1,1,0,1 (5 bits).
REQ-036 SHALL cover: OutReady low for 5 cycles mid-stream -> OutBit/OutValid stable, InReady low after buffer fills, sequence identical to REQ-033.
REQ-037 SHALL cover: Rate switched 2 -> 0 at p = 1 -> remaining p1, p2 follow 3/4; rate 1/2 starts at next p = 0.
REQ-038 SHALL cover: Reset pulsed with 2 bits pending -> OutValid = 0 immediately; next input 1 -> OutBit 1,1, as from zero state.

Source files
------------

// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the transmit chain: code-rate encodings, default
// generator polynomials and the puncture keep table.
package wifi_tx_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  localparam logic [6:0] DEFAULT_G0 = 7'o133;
  localparam logic [6:0] DEFAULT_G1 = 7'o171;

  typedef struct packed {
    logic keep_a;
    logic keep_b;
  } keep_t;

  // The reserved encoding behaves exactly like rate 1/2.
  function automatic rate_e norm_rate(input logic [1:0] r);
    case (r)
      2'd1:    return RATE_2_3;
      2'd2:    return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  function automatic logic [1:0] period_of(input rate_e r);
    case (r)
      RATE_2_3: return 2'd2;
      RATE_3_4: return 2'd3;
      default:  return 2'd1;
    endcase
  endfunction

  function automatic keep_t keep_of(input rate_e r, input logic [1:0] p);
    keep_t k;
    k.keep_a = 1'b1;
    k.keep_b = 1'b1;
    if (r == RATE_2_3 && p == 2'd1) begin
      k.keep_b = 1'b0;
    end
    if (r == RATE_3_4 && p == 2'd1) begin
      k.keep_b = 1'b0;
    end
    if (r == RATE_3_4 && p == 2'd2) begin
      k.keep_a = 1'b0;
    end
    return k;
  endfunction

endpackage

// File: rtl/conv_encoder_core.sv
// Rate-1/2 convolutional encoder core: a K-1 bit history register and the
// two generator parities over {in_bit, s1..s(K-1)}.
module conv_encoder_core #(
  parameter int             K             = 7,
  parameter logic [K-1:0]   G0            = 7'o133,
  parameter logic [K-1:0]   G1            = 7'o171,
  parameter logic [K-2:0]   INITIAL_STATE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic shift_en,
  output logic out_a,
  output logic out_b
);

  // MSB of state_q is s1 (most recent bit), LSB is the oldest delay, so the
  // tap vector lines up with the generator bit ordering directly.
  logic [K-2:0] state_q;
  logic [K-2:0] state_d;
  logic [K-1:0] taps;

  always_comb begin
    state_d = state_q;
    if (shift_en) begin
      state_d = {in_bit, state_q[K-2:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INITIAL_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  assign taps  = {in_bit, state_q};
  assign out_a = ^(taps & G0);
  assign out_b = ^(taps & G1);

endmodule

// File: rtl/punct_conv_encoder.sv
// Punctured convolutional encoder: encodes one bit per acceptance, drops bits
// according to the code rate, and serialises the kept bits through a 2-entry buffer.
module punct_conv_encoder
  import wifi_tx_pkg::*;
#(
  parameter int           K             = 7,
  parameter logic [K-1:0] G0            = K'(DEFAULT_G0),
  parameter logic [K-1:0] G1            = K'(DEFAULT_G1),
  parameter logic [K-2:0] INITIAL_STATE = '0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Rate,
  input  logic       InValid,
  input  logic       InBit,
  output logic       InReady,
  output logic       OutValid,
  output logic       OutBit,
  input  logic       OutReady
);

  rate_e       rate_q, rate_d;
  logic [1:0]  p_q, p_d;
  logic [1:0]  buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        enc_a, enc_b;
  logic        pop, in_ready, accept;
  rate_e       eff_rate;
  keep_t       keep;

  conv_encoder_core #(
    .K             (K),
    .G0            (G0),
    .G1            (G1),
    .INITIAL_STATE (INITIAL_STATE)
  ) u_core (
    .clk      (Clock),
    .rst      (Reset),
    .in_bit   (InBit),
    .shift_en (accept),
    .out_a    (enc_a),
    .out_b    (enc_b)
  );

  // A new rate only takes hold at the start of a puncture period.
  always_comb begin
    pop      = (cnt_q != 2'd0) && OutReady;
    in_ready = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && OutReady);
    accept   = InValid && in_ready;
    eff_rate = (p_q == 2'd0) ? norm_rate(Rate) : rate_q;
    keep     = keep_of(eff_rate, p_q);
  end

  always_comb begin
    rate_d = rate_q;
    p_d    = p_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    if (pop) begin
      buf_d = {1'b0, buf_q[1]};
      cnt_d = cnt_q - 2'd1;
    end
    if (accept) begin
      rate_d = eff_rate;
      p_d    = (p_q == period_of(eff_rate) - 2'd1) ? 2'd0 : p_q + 2'd1;
      // Acceptance only happens once the buffer has drained, so fill from slot 0.
      if (keep.keep_a && keep.keep_b) begin
        buf_d = {enc_b, enc_a};
        cnt_d = 2'd2;
      end else begin
        buf_d = {1'b0, keep.keep_a ? enc_a : enc_b};
        cnt_d = 2'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rate_q <= RATE_1_2;
      p_q    <= 2'd0;
      buf_q  <= 2'd0;
      cnt_q  <= 2'd0;
    end else begin
      rate_q <= rate_d;
      p_q    <= p_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign InReady  = in_ready;
  assign OutValid = (cnt_q != 2'd0);
  assign OutBit   = OutValid & buf_q[0];

endmodule
